speech_sequencer: RTL and testbench

- Parametrised next-generation allophone sequencer for the Speech256 synthesis path.
- Buffers incoming allophone codes in an internal FIFO and walks a control-program ROM through a synchronous read port.
- Presents pitch period and amplitude to the source, and streams a configurable number of filter-section coefficient pairs with section indices.
- Sits between the host/allophone interface and the source + filter chain.

---
 rtl/speech_sequencer_if.sv | 13 +
 rtl/speech_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_speech_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/speech_sequencer_if.sv
// ROM read bus between the speech sequencer and its control-program ROM.
// The sequencer drives the request side (master); the ROM answers with
// its data byte one cycle after a request (slave).
interface speech_sequencer_if #(
    parameter int ROM_AW = 12
);
    logic              rom_en;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;

    modport master (output rom_en, output rom_addr, input  rom_data);
    modport slave  (input  rom_en, input  rom_addr, output rom_data);
endinterface

// File: rtl/speech_sequencer.sv
// speech_sequencer: allophone sequencer for the Speech256 synthesis path.
// Allophone codes are queued in a small FIFO; each one is resolved through a
// jump table in the control ROM to a list of frame records. Every frame sets
// pitch period and amplitude for the source and may stream 2*SECTIONS raw
// filter coefficient bytes with their section indices.
// Optional feature: define ABORT_EN to enable the abort (flush) input;
// without it the abort port is ignored.
module speech_sequencer #(
    parameter int ALLO_W     = 6,
    parameter int ROM_AW     = 12,
    parameter int SECTIONS   = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int DUR_W      = 8
) (
    input  logic                              clk,
    input  logic                              rst_an,
    input  logic [ALLO_W-1:0]                 data_in,
    input  logic                              data_stb,
    output logic                              ldq,
    output logic                              busy,
    speech_sequencer_if.master                rom,
    input  logic                              period_done_in,
    output logic [7:0]                        period_out,
    output logic [15:0]                       amp_out,
    output logic [7:0]                        coeff_out,
    output logic [$clog2(2*SECTIONS)-1:0]     coeff_idx,
    output logic                              coeff_stb,
    input  logic                              abort
);

    localparam int CIDX_W = $clog2(2*SECTIONS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int JHI_W  = ROM_AW - 8;
    localparam logic [CIDX_W-1:0] LAST_IDX = CIDX_W'(2*SECTIONS-1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_JMP_HI = 4'd1,
        S_JMP_LO = 4'd2,
        S_CMD    = 4'd3,
        S_AMP_LO = 4'd4,
        S_AMP_HI = 4'd5,
        S_DUR    = 4'd6,
        S_PER    = 4'd7,
        S_GATE   = 4'd8,
        S_COEF   = 4'd9
    } state_t;

    state_t              state_q, state_d;
    logic                phase_q, phase_d;      // 0: request cycle, 1: capture cycle
    logic [ALLO_W-1:0]   mem_q [FIFO_DEPTH];
    logic [ALLO_W-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [JHI_W-1:0]    jmp_hi_q, jmp_hi_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [15:0]         amp_q, amp_d;
    logic [7:0]          dur_q, dur_d;
    logic [7:0]          per_q, per_d;
    logic [DUR_W-1:0]    duration_q, duration_d;
    logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
    logic [CIDX_W-1:0]   cidx_q, cidx_d;
    logic                rom_en_q, rom_en_d;
    logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
    logic                ldq_q, ldq_d;
    logic                busy_q, busy_d;
    logic [7:0]          period_q, period_d;
    logic [15:0]         amp_out_q, amp_out_d;
    logic [7:0]          coeff_out_q, coeff_out_d;
    logic [CIDX_W-1:0]   coeff_idx_q, coeff_idx_d;
    logic                coeff_stb_q, coeff_stb_d;

    logic                pop_s, push_s;
    logic [ALLO_W-1:0]   head_s;
    logic [ROM_AW-1:0]   next_addr_s;

`ifndef ABORT_EN
    logic                unused_abort_s;
    assign unused_abort_s = abort;
`endif

    // Next-state logic: FIFO bookkeeping, duration counter, ROM walker FSM.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        jmp_hi_d    = jmp_hi_q;
        cmd_d       = cmd_q;
        amp_d       = amp_q;
        dur_d       = dur_q;
        per_d       = per_q;
        duration_d  = duration_q;
        dur_cnt_d   = dur_cnt_q;
        cidx_d      = cidx_q;
        rom_en_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        period_d    = period_q;
        amp_out_d   = amp_out_q;
        coeff_out_d = coeff_out_q;
        coeff_idx_d = coeff_idx_q;
        coeff_stb_d = 1'b0;

        // A pop frees a slot in the same cycle, so a write arriving while
        // full is still taken when it coincides with a pop (count unchanged).
        pop_s       = (state_q == S_IDLE) && (count_q != {CNT_W{1'b0}});
        push_s      = data_stb && (ldq_q || pop_s);
        head_s      = mem_q[rd_ptr_q];
        next_addr_s = rom_addr_q + 1'b1;

        if (push_s) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Saturating period counter; a frame commit below overrides it.
        if (period_done_in && (dur_cnt_q != duration_q)) begin
            dur_cnt_d = dur_cnt_q + 1'b1;
        end else begin
            dur_cnt_d = dur_cnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (pop_s) begin
                    rom_en_d   = 1'b1;
                    rom_addr_d = ROM_AW'({head_s, 1'b0});
                    phase_d    = 1'b0;
                    state_d    = S_JMP_HI;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GATE: begin
                if (dur_cnt_q == duration_q) begin
                    period_d   = per_q;
                    amp_out_d  = {4'b0000, amp_q[15:4]};
                    duration_d = DUR_W'(dur_q);
                    dur_cnt_d  = {DUR_W{1'b0}};
                    rom_en_d   = 1'b1;
                    rom_addr_d = next_addr_s;
                    phase_d    = 1'b0;
                    cidx_d     = {CIDX_W{1'b0}};
                    state_d    = (cmd_q == 8'h02) ? S_COEF : S_CMD;
                end else begin
                    state_d = S_GATE;
                end
            end
            default: begin
                // Every ROM-reading state: request cycle, then capture cycle.
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d    = 1'b0;
                    rom_en_d   = 1'b1;
                    rom_addr_d = next_addr_s;
                    case (state_q)
                        S_JMP_HI: begin
                            jmp_hi_d = rom.rom_data[JHI_W-1:0];
                            state_d  = S_JMP_LO;
                        end
                        S_JMP_LO: begin
                            rom_addr_d = {jmp_hi_q, rom.rom_data};
                            state_d    = S_CMD;
                        end
                        S_CMD: begin
                            cmd_d = rom.rom_data;
                            if (rom.rom_data == 8'h0F) begin
                                rom_en_d = 1'b0;
                                state_d  = S_IDLE;
                            end else begin
                                state_d = S_AMP_LO;
                            end
                        end
                        S_AMP_LO: begin
                            amp_d[7:0] = rom.rom_data;
                            state_d    = S_AMP_HI;
                        end
                        S_AMP_HI: begin
                            amp_d[15:8] = rom.rom_data;
                            state_d     = S_DUR;
                        end
                        S_DUR: begin
                            dur_d   = rom.rom_data;
                            state_d = S_PER;
                        end
                        S_PER: begin
                            // Gate reads nothing; rom_addr keeps pointing at the period byte.
                            per_d      = rom.rom_data;
                            rom_en_d   = 1'b0;
                            rom_addr_d = rom_addr_q;
                            state_d    = S_GATE;
                        end
                        S_COEF: begin
                            coeff_out_d = rom.rom_data;
                            coeff_idx_d = cidx_q;
                            coeff_stb_d = 1'b1;
                            if (cidx_q == LAST_IDX) begin
                                state_d = S_CMD;
                            end else begin
                                cidx_d  = cidx_q + 1'b1;
                                state_d = S_COEF;
                            end
                        end
                        default: begin
                            rom_en_d = 1'b0;
                            state_d  = S_IDLE;
                        end
                    endcase
                end
            end
        endcase

`ifdef ABORT_EN
        // Flush: drop everything queued and in flight, silence the source.
        if (abort) begin
            state_d     = S_IDLE;
            phase_d     = 1'b0;
            wr_ptr_d    = {PTR_W{1'b0}};
            rd_ptr_d    = {PTR_W{1'b0}};
            count_d     = {CNT_W{1'b0}};
            amp_out_d   = 16'h0000;
            coeff_stb_d = 1'b0;
            dur_cnt_d   = {DUR_W{1'b0}};
            duration_d  = {DUR_W{1'b0}};
            rom_en_d    = 1'b0;
        end else begin
            state_d = state_d;
        end
`endif

        busy_d = (state_d != S_IDLE) || (count_d != {CNT_W{1'b0}});
        ldq_d  = (count_d != FULL_CNT);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q     <= S_IDLE;
            phase_q     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {ALLO_W{1'b0}};
            end
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            jmp_hi_q    <= {JHI_W{1'b0}};
            cmd_q       <= 8'h00;
            amp_q       <= 16'h0000;
            dur_q       <= 8'h00;
            per_q       <= 8'h00;
            duration_q  <= {DUR_W{1'b0}};
            dur_cnt_q   <= {DUR_W{1'b0}};
            cidx_q      <= {CIDX_W{1'b0}};
            rom_en_q    <= 1'b0;
            rom_addr_q  <= {ROM_AW{1'b0}};
            ldq_q       <= 1'b1;
            busy_q      <= 1'b0;
            period_q    <= 8'h01;
            amp_out_q   <= 16'h0000;
            coeff_out_q <= 8'h00;
            coeff_idx_q <= {CIDX_W{1'b0}};
            coeff_stb_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            jmp_hi_q    <= jmp_hi_d;
            cmd_q       <= cmd_d;
            amp_q       <= amp_d;
            dur_q       <= dur_d;
            per_q       <= per_d;
            duration_q  <= duration_d;
            dur_cnt_q   <= dur_cnt_d;
            cidx_q      <= cidx_d;
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
            ldq_q       <= ldq_d;
            busy_q      <= busy_d;
            period_q    <= period_d;
            amp_out_q   <= amp_out_d;
            coeff_out_q <= coeff_out_d;
            coeff_idx_q <= coeff_idx_d;
            coeff_stb_q <= coeff_stb_d;
        end
    end

    assign ldq          = ldq_q;
    assign busy         = busy_q;
    assign rom.rom_en   = rom_en_q;
    assign rom.rom_addr = rom_addr_q;
    assign period_out   = period_q;
    assign amp_out      = amp_out_q;
    assign coeff_out    = coeff_out_q;
    assign coeff_idx    = coeff_idx_q;
    assign coeff_stb    = coeff_stb_q;

endmodule

// File: tb/tb_speech_sequencer.sv
// Directed self-checking bench for speech_sequencer with a behavioural ROM.
module tb_speech_sequencer;

    logic        clk = 1'b0;
    logic        rst_an = 1'b0;
    logic [5:0]  data_in = 6'd0;
    logic        data_stb = 1'b0;
    logic        ldq, busy;
    logic        period_done_in = 1'b0;
    logic [7:0]  period_out;
    logic [15:0] amp_out;
    logic [7:0]  coeff_out;
    logic [3:0]  coeff_idx;
    logic        coeff_stb;
    logic        abort = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  rom_mem [0:4095];
    logic [11:0] coef_q [$];     // {idx, data}
    logic [7:0]  per_q [$];
    logic        per_mon_en = 1'b0;
    logic [7:0]  last_per;

    speech_sequencer_if #(.ROM_AW(12)) rom_if ();

    speech_sequencer dut (
        .clk            (clk),
        .rst_an         (rst_an),
        .data_in        (data_in),
        .data_stb       (data_stb),
        .ldq            (ldq),
        .busy           (busy),
        .rom            (rom_if.master),
        .period_done_in (period_done_in),
        .period_out     (period_out),
        .amp_out        (amp_out),
        .coeff_out      (coeff_out),
        .coeff_idx      (coeff_idx),
        .coeff_stb      (coeff_stb),
        .abort          (abort)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data valid the cycle after the request.
    always @(posedge clk) begin
        if (rom_if.rom_en) rom_if.rom_data <= rom_mem[rom_if.rom_addr];
    end

    // Coefficient stream logger.
    always @(negedge clk) begin
        if (coeff_stb) coef_q.push_back({coeff_idx, coeff_out});
    end

    // Logs every change of period_out while enabled.
    always @(negedge clk) begin
        if (per_mon_en && (period_out != last_per)) per_q.push_back(period_out);
        last_per <= period_out;
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic write_allo(input logic [5:0] a);
        data_in  = a;
        data_stb = 1'b1;
        @(negedge clk);
        data_stb = 1'b0;
    endtask

    task automatic pulse_period();
        period_done_in = 1'b1;
        @(negedge clk);
        period_done_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_amp(input string tag, input logic [15:0] exp, input int budget);
        int n = 0;
        while (amp_out !== exp && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {16'd0, amp_out}, {16'd0, exp});
    endtask

    task automatic put_frame(input int base, input logic [7:0] cmd, input logic [15:0] amp,
                             input logic [7:0] dur, input logic [7:0] per);
        rom_mem[base]   = cmd;
        rom_mem[base+1] = amp[7:0];
        rom_mem[base+2] = amp[15:8];
        rom_mem[base+3] = dur;
        rom_mem[base+4] = per;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom_mem[i] = 8'h00;
        // allophone 3 -> 0x120: coefficient frame then end
        rom_mem[6] = 8'h01; rom_mem[7] = 8'h20;
        put_frame(12'h120, 8'h02, 16'h1230, 8'd4, 8'd80);
        for (int i = 0; i < 12; i++) rom_mem[12'h125 + i] = 8'h10 + 8'(i);
        rom_mem[12'h131] = 8'h0F;
        // allophone 4 -> 0x200: two plain frames
        rom_mem[8] = 8'h02; rom_mem[9] = 8'h00;
        put_frame(12'h200, 8'h01, 16'h2000, 8'd3, 8'd50);
        put_frame(12'h205, 8'h01, 16'h4560, 8'd2, 8'd60);
        rom_mem[12'h20A] = 8'h0F;
        // allophones 10..15 -> 0x300 + 8k: one frame each, dur 0, period 100+k
        for (int k = 0; k < 6; k++) begin
            rom_mem[2*(10+k)]   = 8'h03;
            rom_mem[2*(10+k)+1] = 8'(8*k);
            put_frame(12'h300 + 8*k, 8'h01, 16'h1000, 8'd0, 8'(100+k));
            rom_mem[12'h300 + 8*k + 5] = 8'h0F;
        end

        // ---- reset values
        repeat (3) @(negedge clk);
        check("rst_ldq", {31'd0, ldq}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rom_en", {31'd0, rom_if.rom_en}, 32'd0);
        check("rst_rom_addr", {20'd0, rom_if.rom_addr}, 32'd0);
        check("rst_period", {24'd0, period_out}, 32'd1);
        check("rst_amp", {16'd0, amp_out}, 32'd0);
        check("rst_coeff", {24'd0, coeff_out}, 32'd0);
        check("rst_cidx", {28'd0, coeff_idx}, 32'd0);
        check("rst_cstb", {31'd0, coeff_stb}, 32'd0);
        rst_an = 1'b1;
        @(negedge clk);

        // ---- period pulses in idle with duration 0, then allophone 3
        repeat (3) pulse_period();
        check("idle_busy", {31'd0, busy}, 32'd0);
        write_allo(6'd3);
        check("a3_busy", {31'd0, busy}, 32'd1);
        wait_idle("a3", 300);
        check("a3_period", {24'd0, period_out}, 32'd80);
        check("a3_amp", {16'd0, amp_out}, 32'h0123);
        check("a3_ncoef", coef_q.size(), 32'd12);
        for (int i = 0; i < coef_q.size(); i++) begin
            check($sformatf("a3_cidx%0d", i), {28'd0, coef_q[i][11:8]}, i);
            check($sformatf("a3_cdat%0d", i), {24'd0, coef_q[i][7:0]}, 32'h10 + i);
        end
        coef_q.delete();

        // ---- reset during the coefficient stream
        write_allo(6'd3);
        repeat (4) pulse_period();
        begin
            int n = 0;
            while (coeff_stb !== 1'b1 && n < 300) begin
                @(negedge clk);
                n++;
            end
            check("mid_reach_coef", {31'd0, coeff_stb}, 32'd1);
        end
        #2 rst_an = 1'b0;
        #1;
        check("mid_ldq", {31'd0, ldq}, 32'd1);
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_rom_en", {31'd0, rom_if.rom_en}, 32'd0);
        check("mid_rom_addr", {20'd0, rom_if.rom_addr}, 32'd0);
        check("mid_period", {24'd0, period_out}, 32'd1);
        check("mid_amp", {16'd0, amp_out}, 32'd0);
        check("mid_cidx", {28'd0, coeff_idx}, 32'd0);
        check("mid_cstb", {31'd0, coeff_stb}, 32'd0);
        @(negedge clk);
        rst_an = 1'b1;
        coef_q.delete();
        repeat (10) @(negedge clk);
        check("mid_after_busy", {31'd0, busy}, 32'd0);
        check("mid_after_rom_en", {31'd0, rom_if.rom_en}, 32'd0);

        // ---- two-frame allophone: second frame waits exactly 3 pulses
        write_allo(6'd4);
        wait_amp("a4_f1_amp", 16'h0200, 100);
        check("a4_f1_period", {24'd0, period_out}, 32'd50);
        repeat (20) @(negedge clk);
        check("a4_hold0", {16'd0, amp_out}, 32'h0200);
        repeat (2) pulse_period();
        repeat (20) @(negedge clk);
        check("a4_hold2", {16'd0, amp_out}, 32'h0200);
        check("a4_hold2_per", {24'd0, period_out}, 32'd50);
        pulse_period();
        repeat (4) @(negedge clk);
        check("a4_f2_amp", {16'd0, amp_out}, 32'h0456);
        check("a4_f2_period", {24'd0, period_out}, 32'd60);
        wait_idle("a4", 100);
        check("a4_no_coef", coef_q.size(), 32'd0);

        // ---- FIFO fill: 1 playing + 4 buffered, 5th strobe dropped
        per_q.delete();
        per_mon_en = 1'b1;
        write_allo(6'd10);
        repeat (3) @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            data_in  = 6'(10 + k);
            data_stb = 1'b1;
            @(negedge clk);
            if (k == 3) check("fifo_ldq3", {31'd0, ldq}, 32'd1);
            if (k == 4) check("fifo_ldq4", {31'd0, ldq}, 32'd0);
        end
        data_stb = 1'b0;
        check("fifo_ldq5", {31'd0, ldq}, 32'd0);
        check("fifo_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 100; i++) begin
            if (busy === 1'b0) break;
            pulse_period();
        end
        wait_idle("fifo", 50);
        per_mon_en = 1'b0;
        check("fifo_ldq_end", {31'd0, ldq}, 32'd1);
        check("fifo_nplay", per_q.size(), 32'd5);
        for (int i = 0; i < per_q.size(); i++) begin
            check($sformatf("fifo_order%0d", i), {24'd0, per_q[i]}, 32'd100 + i);
        end

`ifdef ABORT_EN
        // ---- abort while gated with two queued entries
        write_allo(6'd4);
        wait_amp("ab_f1_amp", 16'h0200, 100);
        write_allo(6'd10);
        write_allo(6'd11);
        repeat (15) @(negedge clk);
        check("ab_pre_busy", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_amp", {16'd0, amp_out}, 32'd0);
        check("ab_ldq", {31'd0, ldq}, 32'd1);
        check("ab_busy", {31'd0, busy}, 32'd0);
        check("ab_rom_en", {31'd0, rom_if.rom_en}, 32'd0);
        check("ab_cstb", {31'd0, coeff_stb}, 32'd0);
        repeat (10) @(negedge clk);
        check("ab_stay_idle", {31'd0, busy}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
